// File: rtl/uart_rx_if.sv
// Signal bundle between the UART line/configuration side and the receive deserializer.
// The master side drives the serial line and frame configuration; the slave side returns characters and status.
interface uart_rx_if #(
  parameter int DIV_W = 16
);
  logic             rx;
  logic [DIV_W-1:0] divisor;
  logic [1:0]       word_len;
  logic             parity_en;
  logic             parity_even;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             parity_err;
  logic             framing_err;
  logic             break_det;
  logic             busy;

  modport master (
    output rx, divisor, word_len, parity_en, parity_even,
    input  rx_data, rx_valid, parity_err, framing_err, break_det, busy
  );

  modport slave (
    input  rx, divisor, word_len, parity_en, parity_even,
    output rx_data, rx_valid, parity_err, framing_err, break_det, busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x oversampling, start validation, 5-8 data bits LSB-first,
// optional parity, single stop-bit check, and a one-clock character strobe with status flags.
module uart_rx_deserializer #(
  parameter int DIV_W = 16
) (
  input  logic    clk,
  input  logic    reset,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             xor_q, xor_d;
  logic             par_err_q, par_err_d;
  logic             par_bit_q, par_bit_d;
  logic [1:0]       wl_q, wl_d;
  logic             pen_q, pen_d;
  logic             peven_q, peven_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             framing_err_q, framing_err_d;
  logic             break_det_q, break_det_d;
  logic             busy_q, busy_d;

  logic             rx_s;
  logic [DIV_W-1:0] div_eff_s;
  logic             tick_s;
  logic             sample_s;

  assign rx_s      = sync2_q;
  assign div_eff_s = (bus.divisor == {DIV_W{1'b0}}) ? DIV_W'(1) : bus.divisor;
  assign tick_s    = (baud_cnt_q == (div_eff_s - DIV_W'(1)));
  assign sample_s  = tick_s && (os_cnt_q == 4'd7);

  // Next-state, datapath and output computation.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    xor_d         = xor_q;
    par_err_d     = par_err_q;
    par_bit_d     = par_bit_q;
    wl_d          = wl_q;
    pen_d         = pen_q;
    peven_d       = peven_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    break_det_d   = break_det_q;

    if (tick_s) begin
      baud_cnt_d = {DIV_W{1'b0}};
      os_cnt_d   = (os_cnt_q == 4'd15) ? 4'd0 : (os_cnt_q + 4'd1);
    end else begin
      baud_cnt_d = baud_cnt_q + DIV_W'(1);
      os_cnt_d   = os_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          // Restart both counters so every later sample lands mid-bit.
          state_d    = START;
          baud_cnt_d = {DIV_W{1'b0}};
          os_cnt_d   = 4'd0;
          bit_cnt_d  = 3'd0;
          shreg_d    = 8'h00;
          xor_d      = 1'b0;
          par_err_d  = 1'b0;
          par_bit_d  = 1'b0;
          wl_d       = bus.word_len;
          pen_d      = bus.parity_en;
          peven_d    = bus.parity_even;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (sample_s) begin
          state_d = rx_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (sample_s) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          xor_d   = xor_q ^ rx_s;
          // Last bit index is word_len + 4, i.e. {1, word_len}.
          if (bit_cnt_q == {1'b1, wl_q}) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (sample_s) begin
          par_bit_d = rx_s;
          par_err_d = xor_q ^ rx_s ^ ~peven_q;
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (sample_s) begin
          rx_valid_d    = 1'b1;
          rx_data_d     = shreg_q >> (2'd3 - wl_q);
          parity_err_d  = par_err_q;
          framing_err_d = ~rx_s;
          break_det_d   = (shreg_q == 8'h00) & ~par_bit_q & ~rx_s;
          state_d       = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, synchronizer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      baud_cnt_q    <= {DIV_W{1'b0}};
      os_cnt_q      <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shreg_q       <= 8'h00;
      xor_q         <= 1'b0;
      par_err_q     <= 1'b0;
      par_bit_q     <= 1'b0;
      wl_q          <= 2'd0;
      pen_q         <= 1'b0;
      peven_q       <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      break_det_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= bus.rx;
      sync2_q       <= sync1_q;
      baud_cnt_q    <= baud_cnt_d;
      os_cnt_q      <= os_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      xor_q         <= xor_d;
      par_err_q     <= par_err_d;
      par_bit_q     <= par_bit_d;
      wl_q          <= wl_d;
      pen_q         <= pen_d;
      peven_q       <= peven_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      break_det_q   <= break_det_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.framing_err = framing_err_q;
  assign bus.break_det   = break_det_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: directed frames push expected characters,
// a negedge monitor pops and compares whenever rx_valid is seen.
module tb_uart_rx_deserializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.DIV_W(16)) bus ();

  uart_rx_deserializer #(.DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   n_valid = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%02h required 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bd, input logic bsy);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    e.bd   = bd;
    e.busy = bsy;
    exp_q.push_back(e);
  endtask

  // Hold rx at a level for a number of clocks; always called and returns at a negedge.
  task automatic drive(input logic b, input int clks);
    bus.rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_on,
                            input logic par_bit, input logic stop_bit, input int bclk);
    drive(1'b0, bclk);
    for (int i = 0; i < nbits; i++) begin
      drive(d[i], bclk);
    end
    if (par_on) begin
      drive(par_bit, bclk);
    end
    drive(stop_bit, bclk);
    bus.rx = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected characters never arrived within %0d clocks", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.rx_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: rx_data=0x%02h with no frame expected at %0t", bus.rx_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data",     bus.rx_data,     mon_e.data);
        check("parity_err",  bus.parity_err,  8'(mon_e.pe));
        check("framing_err", bus.framing_err, 8'(mon_e.fe));
        check("break_det",   bus.break_det,   8'(mon_e.bd));
        check("busy_at_valid", bus.busy,      8'(mon_e.busy));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.rx          = 1'b1;
    bus.divisor     = 16'd1;
    bus.word_len    = 2'b11;
    bus.parity_en   = 1'b0;
    bus.parity_even = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data",     bus.rx_data,     8'h00);
    check("rst_rx_valid",    bus.rx_valid,    8'h00);
    check("rst_parity_err",  bus.parity_err,  8'h00);
    check("rst_framing_err", bus.framing_err, 8'h00);
    check("rst_break_det",   bus.break_det,   8'h00);
    check("rst_busy",        bus.busy,        8'h00);
    reset = 1'b0;
    drive(1'b1, 32);

    // 8N1 nominal
    push(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
    drive(1'b1, 32);
    wait_drain(200);

    // 7E1, good then bad parity
    bus.word_len    = 2'b10;
    bus.parity_en   = 1'b1;
    bus.parity_even = 1'b1;
    push(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 16);
    drive(1'b1, 32);
    push(8'h35, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 16);
    drive(1'b1, 32);
    wait_drain(200);

    // Framing error with stop bit low
    bus.word_len  = 2'b11;
    bus.parity_en = 1'b0;
    push(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 16);
    drive(1'b1, 32);
    wait_drain(200);

    // Break: 20 bit times low, one character only
    push(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 320);
    check("break_busy_while_low", bus.busy, 8'h01);
    drive(1'b1, 64);
    check("break_busy_after_high", bus.busy, 8'h00);
    wait_drain(50);
    check("valid_count_after_break", 8'(n_valid), 8'd5);

    // False start glitch, then a good frame
    drive(1'b0, 4);
    drive(1'b1, 16);
    check("false_start_busy", bus.busy, 8'h00);
    push(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16);
    drive(1'b1, 32);
    wait_drain(200);

    // Reset during data bit 3 of 0xFF
    drive(1'b0, 16);
    drive(1'b1, 48);
    drive(1'b1, 8);
    check("pre_reset_busy", bus.busy, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rx_data",  bus.rx_data,  8'h00);
    check("midrst_rx_valid", bus.rx_valid, 8'h00);
    check("midrst_busy",     bus.busy,     8'h00);
    reset = 1'b0;
    drive(1'b1, 120);
    push(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 16);
    drive(1'b1, 32);
    wait_drain(200);

    // Back-to-back 5-bit words at divisor 3
    bus.divisor  = 16'd3;
    bus.word_len = 2'b00;
    push(8'h1F, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h15, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 48);
    send_frame(8'h00, 5, 1'b0, 1'b0, 1'b1, 48);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, 48);
    drive(1'b1, 96);
    wait_drain(2000);

    check("total_valid_count", 8'(n_valid), 8'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
